shared_mul_arbiter: RTL and testbench

Shared iterative multiplier with a two-core round-robin arbiter for the dual-core CPU. Each core's EX stage decodes ALU control 4'b0011 (mul) and requests a multiply here instead of owning a multiplier. The block grants one core at a time, sequences a shift-add multiply over multiple cycles, and returns the low WIDTH bits of the product to the granted core with a one-cycle done pulse.

---
 rtl/shared_mul_arbiter_pkg.sv | 38 +++
 rtl/shared_mul_arbiter_mul_seq_core.sv | 76 +++++++
 rtl/shared_mul_arbiter.sv | 152 +++++++++++++++
 tb/tb_shared_mul_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_mul_arbiter_pkg.sv
// Purpose : shared definitions for the two-core iterative multiplier (states, ALU code, widths).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   DEFAULT_WIDTH - default operand/result width
//   ALU_MUL       - EX-stage ALU control code that routes an op to this block
//   mul_state_e   - controller state encoding (IDLE/BUSY/DONE)
//   rr_pick       - round-robin winner selection between the two cores
package shared_mul_arbiter_pkg;

    localparam int         DEFAULT_WIDTH = 32;
    localparam logic [3:0] ALU_MUL       = 4'b0011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_e;

    // Returns the index of the core to grant. With both cores requesting,
    // the core that did not win last time goes next; otherwise whichever
    // core is requesting wins (core 0 when neither is, result unused then).
    function automatic logic rr_pick(input logic req0,
                                     input logic req1,
                                     input logic last_grant);
        logic pick;
        if (req0 && req1) begin
            pick = ~last_grant;
        end else if (req1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/shared_mul_arbiter_mul_seq_core.sv
// Purpose : shift-add multiply datapath (accumulator, shifted operands, step counter).
// Latency : one partial product per 'step' cycle; WIDTH steps (fewer with early termination).
// Backpressure: none; advances only while 'step' is high, 'load' restarts it.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-low reset
//   load              capture op_a/op_b, clear accumulator and counter
//   step              perform one shift-add iteration
//   op_a, op_b        multiplicand, multiplier
//   product           accumulator (low WIDTH bits of the running product)
//   last              the step taken this cycle is the final one
//
// Build option: SHARED_MUL_EARLY_TERM_EN also flags 'last' once the remaining
// multiplier bits are all zero, since further steps cannot change the sum.
module mul_seq_core
    import shared_mul_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic [WIDTH-1:0] product,
    output logic             last
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
        end else if (load) begin
            mcand <= op_a;
            mplr  <= op_b;
            acc   <= '0;
            cnt   <= '0;
        end else if (step) begin
            // Unsigned shift-add modulo 2^WIDTH: the low WIDTH bits equal the
            // two's-complement product, so signed operands need no special case.
            if (mplr[0]) begin
                acc <= acc + mcand;
            end
            mcand <= mcand << 1;
            mplr  <= mplr >> 1;
            cnt   <= cnt + 1'b1;
        end
    end

    logic cnt_last;
    assign cnt_last = (cnt == CNT_W'(WIDTH - 1));

`ifdef SHARED_MUL_EARLY_TERM_EN
    // After this step the multiplier is mplr >> 1; if that is zero no
    // further partial product can be added. A zero multiplier therefore
    // still costs one BUSY cycle.
    logic rest_zero;
    assign rest_zero = ((mplr >> 1) == '0);
    assign last      = cnt_last || rest_zero;
`else
    assign last      = cnt_last;
`endif

    assign product = acc;

endmodule

// File: rtl/shared_mul_arbiter.sv
// Purpose : one iterative multiplier shared by two cores via a round-robin arbiter.
// Latency : ack in cycle 0, BUSY cycles 1..WIDTH, done pulse in cycle WIDTH+1.
// Backpressure: requests are only accepted in IDLE; a requester holds req until its ack.
//
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-low reset
//   req0_i/req1_i                    per-core multiply request (held until ack)
//   src0a_i,src0b_i/src1a_i,src1b_i  per-core multiplicand / multiplier
//   ack0_o/ack1_o                    request accepted this cycle (combinational)
//   done0_o/done1_o                  result valid this cycle
//   result0_o/result1_o              low WIDTH product bits, held until next done
//   busy_o                           high in BUSY and DONE
//
// Build option: SHARED_MUL_EARLY_TERM_EN shortens BUSY once the remaining
// multiplier bits are zero; results are identical either way.
module shared_mul_arbiter
    import shared_mul_arbiter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req0_i,
    input  logic             req1_i,
    input  logic [WIDTH-1:0] src0a_i,
    input  logic [WIDTH-1:0] src0b_i,
    input  logic [WIDTH-1:0] src1a_i,
    input  logic [WIDTH-1:0] src1b_i,
    output logic             ack0_o,
    output logic             ack1_o,
    output logic             done0_o,
    output logic             done1_o,
    output logic [WIDTH-1:0] result0_o,
    output logic [WIDTH-1:0] result1_o,
    output logic             busy_o
);

    mul_state_e       state;
    mul_state_e       state_nxt;
    logic             owner;       // core whose operation is in flight
    logic             last_grant;  // core granted most recently
    logic [WIDTH-1:0] res0_q;
    logic [WIDTH-1:0] res1_q;

    logic             grant;
    logic             load;
    logic             step;
    logic             seq_last;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;

    // ------------------------------------------------------------------
    // Arbitration and operand selection
    // ------------------------------------------------------------------
    assign grant = rr_pick(req0_i, req1_i, last_grant);
    assign op_a  = grant ? src1a_i : src0a_i;
    assign op_b  = grant ? src1b_i : src0b_i;

    // ------------------------------------------------------------------
    // Controller
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ack0_o    = 1'b0;
        ack1_o    = 1'b0;
        done0_o   = 1'b0;
        done1_o   = 1'b0;
        load      = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE: begin
                if (req0_i || req1_i) begin
                    load      = 1'b1;
                    ack0_o    = ~grant;
                    ack1_o    = grant;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                step = 1'b1;
                if (seq_last) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                done0_o   = ~owner;
                done1_o   = owner;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy_o = (state != IDLE);

    // ------------------------------------------------------------------
    // Ownership, fairness and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;  // core 0 wins the first tie after reset
            res0_q     <= '0;
            res1_q     <= '0;
        end else begin
            if (load) begin
                owner      <= grant;
                last_grant <= grant;
            end
            if (done0_o) begin
                res0_q <= product;
            end
            if (done1_o) begin
                res1_q <= product;
            end
        end
    end

    // The accumulator already holds the final product during DONE, so the
    // result is presented in the done cycle itself and the register keeps
    // it visible afterwards.
    assign result0_o = done0_o ? product : res0_q;
    assign result1_o = done1_o ? product : res1_q;

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    mul_seq_core #(
        .WIDTH (WIDTH)
    ) u_seq (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (load),
        .step    (step),
        .op_a    (op_a),
        .op_b    (op_b),
        .product (product),
        .last    (seq_last)
    );

endmodule

// File: tb/tb_shared_mul_arbiter.sv
// Purpose : directed self-checking bench for shared_mul_arbiter.
// Latency : expected ack-to-done latency computed per build (full or early-terminated).
// Backpressure: holds requests until ack, as a core would.
module tb_shared_mul_arbiter;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         req0, req1;
    logic [W-1:0] s0a, s0b, s1a, s1b;
    logic         ack0, ack1, done0, done1, busy;
    logic [W-1:0] res0, res1;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    shared_mul_arbiter #(.WIDTH(W)) dut (
        .clk_i     (clk),
        .rst_i     (rst_n),
        .req0_i    (req0),
        .req1_i    (req1),
        .src0a_i   (s0a),
        .src0b_i   (s0b),
        .src1a_i   (s1a),
        .src1b_i   (s1b),
        .ack0_o    (ack0),
        .ack1_o    (ack1),
        .done0_o   (done0),
        .done1_o   (done1),
        .result0_o (res0),
        .result1_o (res1),
        .busy_o    (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected ack-to-done latency for a given multiplier.
    function automatic int exp_lat(input logic [W-1:0] b);
`ifdef SHARED_MUL_EARLY_TERM_EN
        int n;
        n = 1;
        for (int i = 0; i < W; i++) begin
            if (b[i]) n = i + 1;
        end
        return n + 1;
`else
        return W + 1;
`endif
    endfunction

    task automatic apply_reset();
        rst_n = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        s0a = '0; s0b = '0; s1a = '0; s1b = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Called 1 time unit after a rising edge while the DUT is IDLE; raises the
    // request, checks the ack, then steps to BUSY cycle 1 and drops the request.
    task automatic start_op(input int core, input logic [W-1:0] a, input logic [W-1:0] b);
        if (core == 0) begin
            s0a = a; s0b = b; req0 = 1'b1;
        end else begin
            s1a = a; s1b = b; req1 = 1'b1;
        end
        #1;
        check($sformatf("ack%0d_on_req", core), (core == 0) ? ack0 : ack1, 1'b1);
        check($sformatf("no_other_ack_c%0d", core), (core == 0) ? ack1 : ack0, 1'b0);
        @(posedge clk);
        #1;
        if (core == 0) req0 = 1'b0; else req1 = 1'b0;
    endtask

    // Waits (bounded) for the done pulse of 'core'. Starts at cycle 'start',
    // returns the cycle index of done and the number of acks seen meanwhile.
    task automatic wait_done(input int core, input int start, output int lat, output int acks);
        int c;
        c    = start;
        lat  = -1;
        acks = 0;
        while (c <= 200) begin
            if ((core == 0 && done0) || (core == 1 && done1)) begin
                lat = c;
                break;
            end
            if (ack0 || ack1) acks++;
            @(posedge clk);
            #1;
            c++;
        end
    endtask

    task automatic run_single(input int core, input logic [W-1:0] a, input logic [W-1:0] b,
                              input logic [W-1:0] exp_res, input string tag);
        int lat, acks;
        start_op(core, a, b);
        wait_done(core, 1, lat, acks);
        check({tag, "_lat"}, lat, exp_lat(b));
        check({tag, "_res"}, (core == 0) ? res0 : res1, exp_res);
        check({tag, "_busy_in_done"}, busy, 1'b1);
        check({tag, "_stray_ack"}, acks, 0);
        @(posedge clk);
        #1;
        check({tag, "_done_1cyc"}, (core == 0) ? done0 : done1, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_res_held"}, (core == 0) ? res0 : res1, exp_res);
    endtask

    initial begin
        int lat, acks;

        // ---------------- reset state ----------------
        apply_reset();
        check("rst_ack0", ack0, 1'b0);
        check("rst_ack1", ack1, 1'b0);
        check("rst_done0", done0, 1'b0);
        check("rst_done1", done1, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_res0", res0, 32'd0);
        check("rst_res1", res1, 32'd0);

        // ---------------- core 0 alone: 7 x 6 ----------------
        run_single(0, 32'd7, 32'd6, 32'd42, "c0_7x6");
        check("c0_7x6_res1_untouched", res1, 32'd0);

        // ---------------- simultaneous requests after reset ----------------
        apply_reset();
        s0a = 32'd3; s0b = 32'd5; req0 = 1'b1;
        s1a = 32'd4; s1b = 32'd4; req1 = 1'b1;
        #1;
        check("both_ack0_first", ack0, 1'b1);
        check("both_no_ack1", ack1, 1'b0);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        wait_done(0, 1, lat, acks);
        check("both_c0_lat", lat, exp_lat(32'd5));
        check("both_c0_res", res0, 32'd15);
        check("both_no_ack_busy", acks, 0);
        check("both_no_ack1_in_done", ack1, 1'b0);
        @(posedge clk);
        #1;
        check("both_ack1_after_done", ack1, 1'b1);
        check("both_ack0_quiet", ack0, 1'b0);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        wait_done(1, 1, lat, acks);
        check("both_c1_lat", lat, exp_lat(32'd4));
        check("both_c1_res", res1, 32'd16);
        check("both_c0_res_held", res0, 32'd15);
        @(posedge clk);
        #1;

        // ---------------- signed / wrap-around ----------------
        run_single(0, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, "neg1x2");
        run_single(1, 32'h8000_0000, 32'd2, 32'h0000_0000, "min_x2");
        run_single(1, 32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFF1, "neg3x5");
        run_single(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, "neg1xneg1");

        // ---------------- request while busy, round-robin on return ----------------
        start_op(0, 32'd20, 32'd21);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        s1a = 32'd11; s1b = 32'd13; req1 = 1'b1;
        wait_done(0, 5, lat, acks);
        check("rr_c0_lat", lat, exp_lat(32'd21));
        check("rr_c0_res", res0, 32'd420);
        check("rr_no_ack1_busy", acks, 0);
        // core 0 comes back in the done cycle and must lose the next tie
        s0a = 32'd2; s0b = 32'd3; req0 = 1'b1;
        @(posedge clk);
        #1;
        check("rr_ack1_wins", ack1, 1'b1);
        check("rr_ack0_loses", ack0, 1'b0);
        @(posedge clk);
        #1;
        req1 = 1'b0;
        wait_done(1, 1, lat, acks);
        check("rr_c1_res", res1, 32'd143);
        check("rr_no_ack0_busy", acks, 0);
        check("rr_no_ack0_done", ack0, 1'b0);
        @(posedge clk);
        #1;
        check("rr_ack0_after", ack0, 1'b1);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        wait_done(0, 1, lat, acks);
        check("rr_c0b_res", res0, 32'd6);
        @(posedge clk);
        #1;

        // ---------------- reset at BUSY cycle 10 ----------------
        start_op(0, 32'd5, 32'hFFFF_FFFF);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check("mid_busy_before_rst", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_done0", done0, 1'b0);
        check("mid_rst_ack0", ack0, 1'b0);
        check("mid_rst_res0", res0, 32'd0);
        check("mid_rst_res1", res1, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        lat = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done0 || done1 || busy) lat++;
        end
        check("mid_rst_no_done", lat, 0);
        run_single(0, 32'd6, 32'd7, 32'd42, "post_rst_6x7");

        // ---------------- early-termination boundary operands ----------------
        run_single(0, 32'd9, 32'd1, 32'd9, "c0_9x1");
        run_single(1, 32'd9, 32'd0, 32'd0, "c1_9x0");

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop so a wedged DUT can never hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
